led_seq_ctrl: RTL
=================

# led_seq_ctrl

Sequencer/controller for the board LED pattern datapath (shift register / flash / RGB colour select). Generates the pattern tick, steps through a fixed four-entry playlist of direction, shift-vs-flash and colour settings, and handles run/pause/skip from debounced board buttons. Sits between the board switches/buttons and the LED pattern datapath, which consumes `o_tick` and the configuration outputs.

## Interface
- `NB_COUNT`, 32, prescaler width; tick limit is `2**(NB_COUNT-10+i_speed)-1`
- `NB_DWELL`, 4, dwell counter width
- `DWELL`, 8, pattern ticks per playlist step (1..2**NB_DWELL-1)

- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high
- `i_enable`  in  1  level; 0 forces IDLE
- `i_speed`  in  2  tick-rate select, 0 = fastest
- `i_btn_run`  in  1  synchronous button; rising edge toggles RUN/PAUSE
- `i_btn_skip`  in  1  rising edge advances to the next step
- `i_btn_color`  in  1  rising edge cycles colour override (macro only)
- `o_tick`  out  1  one-cycle pattern advance pulse to the datapath
- `o_dir`  out  1  0 = shift left, 1 = shift right
- `o_flash_sel`  out  1  1 = flash mode, 0 = shift mode
- `o_color`  out  3  {b,g,r}, active bits enable the channels
- `o_step_strobe`  out  1  one-cycle pulse on every step change
- `o_status`  out  4  {step[1:0], state[1:0]}

## Operation
- Button edges: each button input is registered once; edge = `btn & ~btn_q`. Edge registers reset to 0.
- States: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10. 2'b11 is unreachable and recovers to IDLE.
- Priority, highest first: `i_enable`=0, then run edge, then skip edge, then dwell expiry.
- IDLE
  - `i_enable`=1 → RUN.
  - Prescaler held at 0. Step and dwell counters are retained.
  - Skip edges are ignored.
- RUN
  - `i_enable`=0 → IDLE and prescaler cleared.
  - Run edge → PAUSE. A skip edge in the same cycle is dropped.
  - Prescaler counts up. When `prescaler >= limit`: prescaler ← 0, `o_tick`=1, dwell+1.
  - On the tick where `dwell == DWELL-1`: dwell ← 0, step ← step+1 (3 wraps to 0), `o_step_strobe`=1.
- PAUSE
  - Prescaler and dwell are frozen; no ticks.
  - Run edge → RUN. `i_enable`=0 → IDLE.
- Skip (RUN or PAUSE)
  - step+1 mod 4, dwell ← 0, prescaler ← 0, `o_step_strobe`=1.
  - If the same cycle would also tick, the tick is suppressed.
- Playlist, indexed by the step register:
  - step 0: dir 0, flash 0, colour 3'b001
  - step 1: dir 1, flash 0, colour 3'b010
  - step 2: dir 0, flash 1, colour 3'b100
  - step 3: dir 1, flash 0, colour 3'b111
- Limit width: the limit is computed at NB_COUNT width. A change of `i_speed` mid-count takes effect immediately; `>=` guarantees a tick on the next cycle if the count already exceeds the new limit.

## Timing
- All outputs are registered or decoded from registers only; there is no combinational path from any input to any output.
- Reset values:
  - state IDLE, prescaler 0, dwell 0, step 0
  - `o_tick`=0, `o_step_strobe`=0
  - `o_dir`=0, `o_flash_sel`=0, `o_color`=3'b001
  - `o_status`=4'b0000
- Input to state: a button edge is detected 1 cycle after the pin rises. The state changes on the following edge, so `o_status` shows the new state 2 cycles after the pin rise.
- Tick and step change:
  - `o_tick` is high for exactly 1 cycle.
  - On the step-ending tick, `o_tick` and `o_step_strobe` are high in the same cycle.
  - The new configuration is visible from that same cycle: the step register and the strobe update on the same edge.
- Tick period at speed `s`: `2**(NB_COUNT-10+s)` cycles.
- Reset mid-operation: all state returns to reset values immediately (asynchronous).

## Configuration
- Macro: `LED_SEQ_COLOR_OVERRIDE_EN`.
- Defined:
  - A 2-bit override register cycles off→R→G→B→off on each `i_btn_color` edge. The edge is accepted in any state.
  - While not off, `o_color` = the override one-hot (3'b001/3'b010/3'b100) instead of the playlist colour.
  - Override resets to off.
- Undefined: `i_btn_color` is unused and `o_color` always comes from the playlist.

## Test plan
All scenarios use NB_COUNT=12, DWELL=2, so the speed-0 limit is 3 and the tick period is 4 cycles.
- Reset, then `i_enable`=1, speed 0 → `o_status`=4'b0001. `o_tick` pulses every 4 cycles. After 2 ticks: `o_step_strobe`=1, step 1, `o_dir`=1, `o_color`=3'b010.
- Run button pulse while in RUN → `o_status` state=2'b10 and no ticks for 20 cycles. A second pulse resumes; the first tick arrives after the remaining prescaler count.
- In step 3, press skip → step 0, `o_color`=3'b001, one strobe. If this coincides with `prescaler==3`, then `o_tick`=0.
- Run and skip edges in the same cycle from RUN → PAUSE, step unchanged, no strobe.
- Speed 3 while prescaler=10 (limit 31): count continues to 31, then ticks. Switching speed 3→0 at prescaler=10 gives a tick on the next cycle.
- With the macro: 2 colour presses → `o_color`=3'b010 regardless of step; 2 more presses → back to the playlist colour. `i_enable`=0 at any point → IDLE, step retained.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// Pattern sequencer for the board LED datapath: tick prescaler, four-step playlist, run/pause/skip buttons.
// Optional colour override button enabled by defining LED_SEQ_COLOR_OVERRIDE_EN.
module led_seq_ctrl #(
    parameter int NB_COUNT = 32,
    parameter int NB_DWELL = 4,
    parameter int DWELL    = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_enable,
    input  logic [1:0] i_speed,
    input  logic       i_btn_run,
    input  logic       i_btn_skip,
    input  logic       i_btn_color,
    output logic       o_tick,
    output logic       o_dir,
    output logic       o_flash_sel,
    output logic [2:0] o_color,
    output logic       o_step_strobe,
    output logic [3:0] o_status
);

    // state  | meaning
    // IDLE   | disabled, prescaler held at 0, step/dwell retained
    // RUN    | prescaler counting, ticks advance dwell and step
    // PAUSE  | prescaler and dwell frozen, skip still accepted
    // BAD    | unreachable, recovers to IDLE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    localparam logic [NB_COUNT-1:0] ONE        = NB_COUNT'(1);
    localparam int unsigned         SHIFT_BASE = NB_COUNT - 10;
    localparam logic [NB_DWELL-1:0] DWELL_LAST = NB_DWELL'(DWELL - 1);

    state_t              state_q, state_d;
    logic [NB_COUNT-1:0] presc_q, presc_d;
    logic [NB_DWELL-1:0] dwell_q, dwell_d;
    logic [1:0]          step_q, step_d;
    logic                tick_q, tick_d;
    logic                strobe_q, strobe_d;
    logic                btn_run_q, btn_run_d;
    logic                btn_skip_q, btn_skip_d;
    logic                run_edge_q, run_edge_d;
    logic                skip_edge_q, skip_edge_d;
    logic [NB_COUNT-1:0] limit;
    logic [2:0]          pl_color;

    always_comb begin
        limit       = (ONE << (SHIFT_BASE + 32'(i_speed))) - ONE;
        btn_run_d   = i_btn_run;
        btn_skip_d  = i_btn_skip;
        run_edge_d  = i_btn_run & ~btn_run_q;
        skip_edge_d = i_btn_skip & ~btn_skip_q;
    end

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        dwell_d  = dwell_q;
        step_d   = step_q;
        tick_d   = 1'b0;
        strobe_d = 1'b0;
        if (!i_enable) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
                ST_RUN, ST_PAUSE: begin
                    if (run_edge_q) begin
                        // a skip edge arriving with the run edge is dropped
                        state_d = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
                    end else if (skip_edge_q) begin
                        step_d   = step_q + 2'd1;
                        dwell_d  = '0;
                        presc_d  = '0;
                        strobe_d = 1'b1;
                    end else if (state_q == ST_RUN) begin
                        if (presc_q >= limit) begin
                            presc_d = '0;
                            tick_d  = 1'b1;
                            if (dwell_q == DWELL_LAST) begin
                                dwell_d  = '0;
                                step_d   = step_q + 2'd1;
                                strobe_d = 1'b1;
                            end else begin
                                dwell_d = dwell_q + 1'b1;
                            end
                        end else begin
                            presc_d = presc_q + ONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    presc_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            dwell_q     <= '0;
            step_q      <= 2'd0;
            tick_q      <= 1'b0;
            strobe_q    <= 1'b0;
            btn_run_q   <= 1'b0;
            btn_skip_q  <= 1'b0;
            run_edge_q  <= 1'b0;
            skip_edge_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            step_q      <= step_d;
            tick_q      <= tick_d;
            strobe_q    <= strobe_d;
            btn_run_q   <= btn_run_d;
            btn_skip_q  <= btn_skip_d;
            run_edge_q  <= run_edge_d;
            skip_edge_q <= skip_edge_d;
        end
    end

    always_comb begin
        o_dir       = 1'b0;
        o_flash_sel = 1'b0;
        pl_color    = 3'b001;
        case (step_q)
            2'd0: begin o_dir = 1'b0; o_flash_sel = 1'b0; pl_color = 3'b001; end
            2'd1: begin o_dir = 1'b1; o_flash_sel = 1'b0; pl_color = 3'b010; end
            2'd2: begin o_dir = 1'b0; o_flash_sel = 1'b1; pl_color = 3'b100; end
            default: begin o_dir = 1'b1; o_flash_sel = 1'b0; pl_color = 3'b111; end
        endcase
    end

`ifdef LED_SEQ_COLOR_OVERRIDE_EN
    logic [1:0] override_q, override_d;
    logic       btn_color_q, btn_color_d;
    logic       color_edge_q, color_edge_d;

    always_comb begin
        btn_color_d  = i_btn_color;
        color_edge_d = i_btn_color & ~btn_color_q;
        override_d   = override_q + {1'b0, color_edge_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            override_q   <= 2'd0;
            btn_color_q  <= 1'b0;
            color_edge_q <= 1'b0;
        end else begin
            override_q   <= override_d;
            btn_color_q  <= btn_color_d;
            color_edge_q <= color_edge_d;
        end
    end

    always_comb begin
        case (override_q)
            2'd1:    o_color = 3'b001;
            2'd2:    o_color = 3'b010;
            2'd3:    o_color = 3'b100;
            default: o_color = pl_color;
        endcase
    end
`else
    logic unused_btn_color;
    assign unused_btn_color = i_btn_color;
    assign o_color          = pl_color;
`endif

    assign o_tick        = tick_q;
    assign o_step_strobe = strobe_q;
    assign o_status      = {step_q, state_q};

endmodule
